spi_reg_ctrl: RTL and testbench
===============================

# spi_reg_ctrl

Register-file controller behind the SPI slave's word interface. It decodes the first 16-bit word of each chip-enable frame as a command, then runs an auto-incrementing burst read or write over an 8-entry, 16-bit register map. It preloads the next response word onto the slave's parallel input and latches thermocouple samples with sticky status flags. It is the only block that sequences the SPI slave.

## Interface
Parameters:
- `WORD_SIZE`, default 16: SPI word width. Only 16 is supported.
- `ID_VALUE`, default 16'h7C05: value returned by the ID register.

Ports:
- `i_clk`  in  1  system clock; all inputs are synchronous to it
- `i_rst`  in  1  synchronous reset, active-high
- `i_sce`  in  1  SPI chip enable, active low (same signal as the slave's)
- `i_wword`  in  16  received word from the slave
- `i_wstb`  in  1  one-cycle pulse; `i_wword` is valid in that cycle
- `o_win`  out  16  response word to the slave; held stable for the whole word
- `i_sample`  in  16  thermocouple sample
- `i_sample_vld`  in  1  one-cycle pulse; latch `i_sample`
- `o_ctrl`  out  16  CTRL register
- `o_ctrl_wr`  out  1  one-cycle pulse when CTRL is written
- `o_cfg`  out  64  registers 4..7 concatenated, reg4 in bits [15:0]

## Operation
Register map (3-bit address, wraps 7→0):
- 0 ID: RO, `ID_VALUE`.
- 1 STATUS: RO.
  - bit0 RDY: sample latched since last STATUS read.
  - bit1 OVF: a sample arrived while RDY was set.
  - bit2 PERR: parity error.
  - Bits 15:3 read 0.
- 2 SAMPLE: RO, last latched `i_sample`.
- 3 CTRL: RW.
- 4..7 CFG0..3: RW.

Command word fields:
- bit15 W: 1 = write, 0 = read.
- bit14 P: parity bit, used only when parity is enabled.
- bits[2:0]: start address.
- bits[13:3]: reserved, ignored.

States:
- IDLE
  - `o_win` is loaded with STATUS every cycle. This load has no clear side-effect.
  - `i_sce`=0 → CMD.
- CMD
  - `o_win` is held.
  - On `i_wstb`: latch address and W.
  - If read: `o_win` ← reg[addr], apply read side-effect → RD.
  - If write: → WR.
- RD, on each `i_wstb`:
  - addr ← addr+1.
  - `o_win` ← reg[addr+1], apply read side-effect.
  - The received word is discarded.
- WR, on each `i_wstb`:
  - Write `i_wword` to reg[addr]; writes to RO addresses are ignored.
  - addr ← addr+1.
  - `o_win` holds its value.
- ERR
  - `o_win` = 16'hFFFF.
  - Every `i_wstb` is ignored.

Any state with `i_sce`=1 → IDLE on the next cycle, regardless of `i_wstb`. A partial burst is discarded, and earlier burst writes remain committed.

Read side-effect:
- Loading STATUS into `o_win` in RD or CMD clears RDY, OVF and PERR.
- A set event in the same cycle wins: that bit ends at 1.

Sample capture:
- On `i_sample_vld`: SAMPLE ← `i_sample`, RDY ← 1.
- OVF ← 1 if RDY was already 1 and no clear occurs in the same cycle.
- `o_win` holds a snapshot, so a sample arriving during a SAMPLE read never tears the word being shifted.

Write effects:
- A write to CTRL pulses `o_ctrl_wr` for exactly one cycle, in the cycle the register updates.

## Timing
- Reset values:
  - State IDLE.
  - `o_win`, `o_ctrl`, `o_cfg`, SAMPLE, STATUS: all 0.
  - `o_ctrl_wr`: 0.
- Reset takes priority over every other event.
- Reset during a frame: IDLE, no write commits. The controller stays idle until `i_sce` is seen at 0 after reset deasserts.
- Latency from `i_wstb` in cycle N:
  - Register write, `o_ctrl_wr` and `o_win` update all take effect at the clock edge ending cycle N, visible in N+1.
  - STATUS clear also takes effect in N+1.
- `o_win` changes only:
  - in IDLE, or
  - on the cycle after an `i_wstb` accepted in CMD or RD, or
  - on entry to ERR.
- `i_wstb` while `i_sce`=1 is ignored.
- `i_wstb` on the same cycle `i_sce` rises is also ignored.
- Back-to-back `i_wstb` on consecutive cycles must each be processed.

## Configuration
Macro: `SPI_REG_PARITY_EN`.
- Defined:
  - A command word must have even parity over all 16 bits.
  - On failure: PERR ← 1, → ERR, no register is modified.
- Undefined:
  - bit14 is ignored.
  - PERR always reads 0.
  - The ERR state is not generated.

## Test plan
- Reset, then a frame with command 16'h0000 and one extra word.
  - First response = 0.
  - Second response = 16'h7C05.
  - Third response would be STATUS.
- Write burst: command 16'h8003, then 16'hA5A5, 16'h1234.
  - `o_ctrl`=16'hA5A5 with a one-cycle `o_ctrl_wr`.
  - `o_cfg[15:0]`=16'h1234.
- Sample and status:
  - `i_sample_vld` with 16'h0321, then again with 16'h0400.
  - Read from address 1: STATUS=16'h0003, SAMPLE=16'h0400.
  - A second STATUS read returns 16'h0000.
- Clear/set race: `i_sample_vld` in the same cycle as the STATUS load in RD.
  - RDY remains 1.
- Wrap and abort:
  - Read burst starting at address 7 returns reg7, then reg0.
  - Raise `i_sce` mid-word during a write burst: the partial word is not written, and the state returns to IDLE.
- With `SPI_REG_PARITY_EN`: command 16'h8003 (odd parity).
  - Responses are 16'hFFFF.
  - CTRL is unchanged.
  - STATUS bit2 is set.

Source files
------------

// File: rtl/spi_reg_ctrl.sv
// Command/burst register controller sequencing the SPI slave word interface.
// Optional command parity checking is enabled by defining SPI_REG_PARITY_EN.
module spi_reg_ctrl #(
    parameter int                   WORD_SIZE = 16,
    parameter logic [WORD_SIZE-1:0] ID_VALUE  = 16'h7C05
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_sce,
    input  logic [WORD_SIZE-1:0]     i_wword,
    input  logic                     i_wstb,
    output logic [WORD_SIZE-1:0]     o_win,
    input  logic [WORD_SIZE-1:0]     i_sample,
    input  logic                     i_sample_vld,
    output logic [WORD_SIZE-1:0]     o_ctrl,
    output logic                     o_ctrl_wr,
    output logic [4*WORD_SIZE-1:0]   o_cfg
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_RD,
        S_WR,
        S_ERR
    } state_t;

    state_t                          state_q, state_d;
    logic [2:0]                      addr_q, addr_d;
    logic [WORD_SIZE-1:0]            win_q, win_d;
    logic [WORD_SIZE-1:0]            ctrl_q, ctrl_d;
    logic                            ctrl_wr_q, ctrl_wr_d;
    logic [3:0][WORD_SIZE-1:0]       cfg_q, cfg_d;
    logic [WORD_SIZE-1:0]            sample_q, sample_d;
    logic                            rdy_q, rdy_d;
    logic                            ovf_q, ovf_d;
    logic                            perr_q, perr_d;

    logic [2:0]                      rd_addr;
    logic [WORD_SIZE-1:0]            rd_data;
    logic [WORD_SIZE-1:0]            status_word;
    logic                            cmd_ok;
    logic                            stat_clr;
    logic                            perr_set;

    always_comb begin
        status_word      = '0;
        status_word[2:0] = {perr_q, ovf_q, rdy_q};
    end

    // In CMD the read address comes straight from the command word.
    always_comb begin
        if (state_q == S_CMD) begin
            rd_addr = i_wword[2:0];
        end else begin
            rd_addr = 3'(addr_q + 3'd1);
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_addr)
            3'd0:    rd_data = ID_VALUE;
            3'd1:    rd_data = status_word;
            3'd2:    rd_data = sample_q;
            3'd3:    rd_data = ctrl_q;
            default: rd_data = cfg_q[rd_addr[1:0]];
        endcase
    end

    always_comb begin
        cmd_ok = 1'b1;
`ifdef SPI_REG_PARITY_EN
        cmd_ok = ~(^i_wword);
`endif
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        win_d     = win_q;
        ctrl_d    = ctrl_q;
        ctrl_wr_d = 1'b0;
        cfg_d     = cfg_q;
        sample_d  = sample_q;
        rdy_d     = rdy_q;
        ovf_d     = ovf_q;
        perr_d    = perr_q;
        stat_clr  = 1'b0;
        perr_set  = 1'b0;

        case (state_q)
            S_IDLE: begin
                win_d = status_word;
                if (!i_sce) begin
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (i_sce) begin
                    state_d = S_IDLE;
                end else if (i_wstb) begin
                    if (!cmd_ok) begin
                        perr_set = 1'b1;
                        win_d    = '1;
                        state_d  = S_ERR;
                    end else begin
                        addr_d = i_wword[2:0];
                        if (i_wword[15]) begin
                            state_d = S_WR;
                        end else begin
                            win_d    = rd_data;
                            stat_clr = (rd_addr == 3'd1);
                            state_d  = S_RD;
                        end
                    end
                end
            end
            S_RD: begin
                if (i_sce) begin
                    state_d = S_IDLE;
                end else if (i_wstb) begin
                    addr_d   = 3'(addr_q + 3'd1);
                    win_d    = rd_data;
                    stat_clr = (rd_addr == 3'd1);
                end
            end
            S_WR: begin
                if (i_sce) begin
                    state_d = S_IDLE;
                end else if (i_wstb) begin
                    if (addr_q == 3'd3) begin
                        ctrl_d    = i_wword;
                        ctrl_wr_d = 1'b1;
                    end else if (addr_q[2]) begin
                        cfg_d[addr_q[1:0]] = i_wword;
                    end
                    addr_d = 3'(addr_q + 3'd1);
                end
            end
            S_ERR: begin
                win_d = '1;
                if (i_sce) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Clear first so a same-cycle set event wins; OVF only sets without a clear.
        if (stat_clr) begin
            rdy_d  = 1'b0;
            ovf_d  = 1'b0;
            perr_d = 1'b0;
        end
        if (i_sample_vld) begin
            sample_d = i_sample;
            rdy_d    = 1'b1;
            if (rdy_q && !stat_clr) begin
                ovf_d = 1'b1;
            end
        end
        if (perr_set) begin
            perr_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            win_q     <= '0;
            ctrl_q    <= '0;
            ctrl_wr_q <= 1'b0;
            cfg_q     <= '0;
            sample_q  <= '0;
            rdy_q     <= 1'b0;
            ovf_q     <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            win_q     <= win_d;
            ctrl_q    <= ctrl_d;
            ctrl_wr_q <= ctrl_wr_d;
            cfg_q     <= cfg_d;
            sample_q  <= sample_d;
            rdy_q     <= rdy_d;
            ovf_q     <= ovf_d;
            perr_q    <= perr_d;
        end
    end

    assign o_win     = win_q;
    assign o_ctrl    = ctrl_q;
    assign o_ctrl_wr = ctrl_wr_q;
    assign o_cfg     = cfg_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: acts as the SPI slave word interface and
// scoreboards every response word presented on o_win.
module tb_spi_reg_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_sce;
    logic [15:0] i_wword;
    logic        i_wstb;
    logic [15:0] o_win;
    logic [15:0] i_sample;
    logic        i_sample_vld;
    logic [15:0] o_ctrl;
    logic        o_ctrl_wr;
    logic [63:0] o_cfg;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [15:0] sb[$];
    logic [15:0] st_exp;

    spi_reg_ctrl #(.WORD_SIZE(16), .ID_VALUE(16'h7C05)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_sce        (i_sce),
        .i_wword      (i_wword),
        .i_wstb       (i_wstb),
        .o_win        (o_win),
        .i_sample     (i_sample),
        .i_sample_vld (i_sample_vld),
        .o_ctrl       (o_ctrl),
        .o_ctrl_wr    (o_ctrl_wr),
        .o_cfg        (o_cfg)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare the word currently presented to the slave with the oldest expectation.
    task automatic pop_chk(input string tag);
        logic [15:0] e;
        if (sb.size() != 0) e = sb.pop_front();
        else e = 'x;
        chk({tag, "_resp"}, {48'd0, o_win}, {48'd0, e});
        tick();
        tick();
        chk({tag, "_hold"}, {48'd0, o_win}, {48'd0, e});
    endtask

    task automatic frame_begin(input logic [15:0] idle_status);
        i_sce = 1'b0;
        sb.push_back(idle_status);
        tick();
    endtask

    task automatic frame_end();
        i_sce = 1'b1;
        tick();
        tick();
    endtask

    task automatic word(input string tag, input logic [15:0] w, input logic [15:0] exp_next,
                        input logic vld, input logic [15:0] smp);
        pop_chk(tag);
        sb.push_back(exp_next);
        i_wword      = w;
        i_wstb       = 1'b1;
        i_sample_vld = vld;
        i_sample     = smp;
        tick();
        i_wstb       = 1'b0;
        i_sample_vld = 1'b0;
    endtask

    task automatic sample(input logic [15:0] smp);
        i_sample     = smp;
        i_sample_vld = 1'b1;
        tick();
        i_sample_vld = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1; i_sce = 1'b1; i_wword = '0; i_wstb = 1'b0;
        i_sample = '0; i_sample_vld = 1'b0;
        tick(); tick(); tick();
        chk("rst_win", {48'd0, o_win}, 64'd0);
        i_rst = 1'b0;
        tick();
        chk("rst_ctrl", {48'd0, o_ctrl}, 64'd0);
        chk("rst_ctrl_wr", {63'd0, o_ctrl_wr}, 64'd0);
        chk("rst_cfg", o_cfg, 64'd0);
        chk("rst_win_idle", {48'd0, o_win}, 64'd0);

        // ID read, then STATUS follows
        frame_begin(16'h0000);
        word("id_cmd", 16'h0000, 16'h7C05, 1'b0, 16'h0);
        word("id_w1", 16'hABCD, 16'h0000, 1'b0, 16'h0);
        pop_chk("id_tail");
        frame_end();

        // two samples: RDY and OVF set, SAMPLE holds the second
        sample(16'h0321);
        sample(16'h0400);
        tick();
        chk("st_idle", {48'd0, o_win}, 64'h0003);
        frame_begin(16'h0003);
        word("st_cmd", 16'h0001, 16'h0003, 1'b0, 16'h0);
        word("st_w1", 16'h0000, 16'h0400, 1'b0, 16'h0);
        pop_chk("st_tail");
        frame_end();

        // second STATUS read sees cleared flags; sample mid-word must not tear
        frame_begin(16'h0000);
        word("st2_cmd", 16'h0001, 16'h0000, 1'b0, 16'h0);
        word("st2_w1", 16'h0000, 16'h0400, 1'b0, 16'h0);
        pop_chk("st2_tail");
        sample(16'h0555);
        chk("no_tear", {48'd0, o_win}, 64'h0400);
        frame_end();

        // clear/set race on STATUS load in RD
        frame_begin(16'h0001);
        word("race_cmd", 16'h0000, 16'h7C05, 1'b0, 16'h0);
        word("race_w1", 16'h0000, 16'h0001, 1'b1, 16'h0777);
        pop_chk("race_tail");
        frame_end();
        chk("race_status", {48'd0, o_win}, 64'h0001);

        // write burst CTRL, CFG0
        frame_begin(16'h0001);
        word("wr_cmd", 16'h8003, 16'h0001, 1'b0, 16'h0);
        word("wr_ctrl", 16'hA5A5, 16'h0001, 1'b0, 16'h0);
        chk("ctrl_val", {48'd0, o_ctrl}, 64'hA5A5);
        chk("ctrl_wr_pulse", {63'd0, o_ctrl_wr}, 64'd1);
        tick();
        chk("ctrl_wr_end", {63'd0, o_ctrl_wr}, 64'd0);
        word("wr_cfg0", 16'h1234, 16'h0001, 1'b0, 16'h0);
        chk("cfg0_val", {48'd0, o_cfg[15:0]}, 64'h1234);
        chk("ctrl_wr_cfg", {63'd0, o_ctrl_wr}, 64'd0);
        pop_chk("wr_tail");
        frame_end();

        // back-to-back strobes into CFG1..CFG3
        frame_begin(16'h0001);
        word("b2b_cmd", 16'h8005, 16'h0001, 1'b0, 16'h0);
        i_wstb = 1'b1;
        i_wword = 16'hBEEF; tick();
        i_wword = 16'hCAFE; tick();
        i_wword = 16'h0F0F; tick();
        i_wstb = 1'b0;
        chk("b2b_cfg", o_cfg, 64'h0F0F_CAFE_BEEF_1234);
        pop_chk("b2b_tail");
        frame_end();

        // read wraps from 7 to 0
        frame_begin(16'h0001);
        word("wrap_cmd", 16'h0007, 16'h0F0F, 1'b0, 16'h0);
        word("wrap_w1", 16'h0000, 16'h7C05, 1'b0, 16'h0);
        pop_chk("wrap_tail");
        frame_end();

        // abort mid-word; strobes with sce high are ignored
        frame_begin(16'h0001);
        word("ab_cmd", 16'h8004, 16'h0001, 1'b0, 16'h0);
        word("ab_w1", 16'h1111, 16'h0001, 1'b0, 16'h0);
        pop_chk("ab_tail");
        i_sce = 1'b1; i_wstb = 1'b1; i_wword = 16'hDEAD;
        tick();
        tick();
        i_wstb = 1'b0;
        chk("ab_cfg", o_cfg, 64'h0F0F_CAFE_BEEF_1111);
        chk("ab_idle", {48'd0, o_win}, 64'h0001);
        frame_begin(16'h0001);
        word("ab_rd_cmd", 16'h0004, 16'h1111, 1'b0, 16'h0);
        pop_chk("ab_rd_tail");
        frame_end();
        st_exp = 16'h0001;

`ifdef SPI_REG_PARITY_EN
        frame_begin(16'h0001);
        word("par_cmd", 16'h8003, 16'hFFFF, 1'b0, 16'h0);
        word("par_w1", 16'h5555, 16'hFFFF, 1'b0, 16'h0);
        pop_chk("par_tail");
        chk("par_ctrl", {48'd0, o_ctrl}, 64'hA5A5);
        frame_end();
        chk("par_status", {48'd0, o_win}, 64'h0005);
        st_exp = 16'h0005;
`endif

        // reset in the middle of a write burst
        frame_begin(st_exp);
        word("rs_cmd", 16'h8003, st_exp, 1'b0, 16'h0);
        pop_chk("rs_tail");
        i_rst = 1'b1; i_wstb = 1'b1; i_wword = 16'hDEAD;
        tick();
        i_rst = 1'b0; i_wstb = 1'b0; i_sce = 1'b1;
        chk("rs_ctrl", {48'd0, o_ctrl}, 64'd0);
        chk("rs_ctrl_wr", {63'd0, o_ctrl_wr}, 64'd0);
        chk("rs_cfg", o_cfg, 64'd0);
        chk("rs_win", {48'd0, o_win}, 64'd0);
        tick();
        chk("rs_idle", {48'd0, o_win}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
